// File: rtl/sprite_fetch_scheduler.sv
// Per-pixel scheduler sharing one synchronous sprite ROM between the fireboy and icegirl layers.
// Hit-tests both sprites on a pixel strobe, reads fireboy then icegirl, and commits both layers on one edge.
module sprite_fetch_scheduler #(
    parameter int unsigned SPR_W   = 32,
    parameter int unsigned SPR_H   = 32,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned FB_BASE = 0,
    parameter int unsigned IG_BASE = 4096
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pixel_strobe,
    input  logic [9:0]        NextX,
    input  logic [9:0]        NextY,
    input  logic [9:0]        fb_x,
    input  logic [9:0]        fb_y,
    input  logic [9:0]        ig_x,
    input  logic [9:0]        ig_y,
    input  logic [1:0]        fb_frame,
    input  logic [1:0]        ig_frame,
    input  logic              fb_flip,
    input  logic              ig_flip,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [7:0]        rom_q,
    output logic              is_fireboy,
    output logic [7:0]        fireboy_data,
    output logic              is_icegirl,
    output logic [7:0]        icegirl_data,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned DX_W = $clog2(SPR_W);
    localparam int unsigned DY_W = $clog2(SPR_H);

    typedef enum logic [1:0] {IDLE, ADDR_FB, ADDR_IG, CAP_IG} state_t;

    // Bounds are compared 11 bits wide so a sprite near the right/bottom edge never wraps to 0.
    function automatic logic hit_test(input logic [9:0] px, input logic [9:0] py,
                                      input logic [9:0] ox, input logic [9:0] oy);
        return ({1'b0, px} >= {1'b0, ox}) && ({1'b0, px} < ({1'b0, ox} + 11'(SPR_W))) &&
               ({1'b0, py} >= {1'b0, oy}) && ({1'b0, py} < ({1'b0, oy} + 11'(SPR_H)));
    endfunction

    function automatic logic [ADDR_W-1:0] sprite_addr(input logic [9:0] px, input logic [9:0] py,
                                                      input logic [9:0] ox, input logic [9:0] oy,
                                                      input logic [1:0] frame, input logic flip,
                                                      input int unsigned base);
        logic [DX_W-1:0] dx;
        logic [DY_W-1:0] dy;
        logic [31:0]     sum;
        dx = DX_W'(px - ox);
        dy = DY_W'(py - oy);
        if (flip) dx = DX_W'(SPR_W - 1) - dx;
        sum = base + 32'(frame) * (SPR_W * SPR_H) + 32'(dy) * SPR_W + 32'(dx);
        return ADDR_W'(sum);
    endfunction

    state_t             state_q, state_d;
    logic               hit_fb_q, hit_fb_d, hit_ig_q, hit_ig_d;
    logic [ADDR_W-1:0]  ig_addr_q, ig_addr_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               rom_rd_q, rom_rd_d;
    logic [7:0]         fb_buf_q, fb_buf_d;
    logic               is_fireboy_q, is_fireboy_d, is_icegirl_q, is_icegirl_d;
    logic [7:0]         fireboy_data_q, fireboy_data_d, icegirl_data_q, icegirl_data_d;
    logic               busy_q, busy_d, overrun_q, overrun_d;

    logic               fb_hit_c, ig_hit_c;
    logic [ADDR_W-1:0]  fb_addr_c, ig_addr_c;

    always_comb begin
        fb_hit_c  = hit_test(NextX, NextY, fb_x, fb_y);
        ig_hit_c  = hit_test(NextX, NextY, ig_x, ig_y);
        fb_addr_c = sprite_addr(NextX, NextY, fb_x, fb_y, fb_frame, fb_flip, FB_BASE);
        ig_addr_c = sprite_addr(NextX, NextY, ig_x, ig_y, ig_frame, ig_flip, IG_BASE);
    end

    // Next-state and registered-output logic; rom_addr only moves when a read is issued.
    always_comb begin
        state_d        = state_q;
        hit_fb_d       = hit_fb_q;
        hit_ig_d       = hit_ig_q;
        ig_addr_d      = ig_addr_q;
        rom_addr_d     = rom_addr_q;
        rom_rd_d       = 1'b0;
        fb_buf_d       = fb_buf_q;
        is_fireboy_d   = is_fireboy_q;
        fireboy_data_d = fireboy_data_q;
        is_icegirl_d   = is_icegirl_q;
        icegirl_data_d = icegirl_data_q;
        overrun_d      = overrun_q;

        case (state_q)
            IDLE: begin
                if (pixel_strobe) begin
                    hit_fb_d  = fb_hit_c;
                    hit_ig_d  = ig_hit_c;
                    ig_addr_d = ig_addr_c;
                    rom_rd_d  = fb_hit_c;
                    if (fb_hit_c) rom_addr_d = fb_addr_c;
                    state_d   = ADDR_FB;
                end
            end
            ADDR_FB: begin
                rom_rd_d = hit_ig_q;
                if (hit_ig_q) rom_addr_d = ig_addr_q;
                state_d  = ADDR_IG;
            end
            ADDR_IG: begin
                fb_buf_d = hit_fb_q ? rom_q : 8'h00;
                state_d  = CAP_IG;
            end
            CAP_IG: begin
                is_fireboy_d   = hit_fb_q;
                fireboy_data_d = fb_buf_q;
                is_icegirl_d   = hit_ig_q;
                icegirl_data_d = hit_ig_q ? rom_q : 8'h00;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pixel_strobe && (state_q != IDLE)) overrun_d = 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= IDLE;
            hit_fb_q       <= 1'b0;
            hit_ig_q       <= 1'b0;
            ig_addr_q      <= '0;
            rom_addr_q     <= '0;
            rom_rd_q       <= 1'b0;
            fb_buf_q       <= 8'h00;
            is_fireboy_q   <= 1'b0;
            fireboy_data_q <= 8'h00;
            is_icegirl_q   <= 1'b0;
            icegirl_data_q <= 8'h00;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            hit_fb_q       <= hit_fb_d;
            hit_ig_q       <= hit_ig_d;
            ig_addr_q      <= ig_addr_d;
            rom_addr_q     <= rom_addr_d;
            rom_rd_q       <= rom_rd_d;
            fb_buf_q       <= fb_buf_d;
            is_fireboy_q   <= is_fireboy_d;
            fireboy_data_q <= fireboy_data_d;
            is_icegirl_q   <= is_icegirl_d;
            icegirl_data_q <= icegirl_data_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign rom_rd       = rom_rd_q;
    assign is_fireboy   = is_fireboy_q;
    assign fireboy_data = fireboy_data_q;
    assign is_icegirl   = is_icegirl_q;
    assign icegirl_data = icegirl_data_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Randomized self-checking bench for sprite_fetch_scheduler against a pixel-level reference model
// with a synchronous ROM model filled with random bytes.
module tb_sprite_fetch_scheduler;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pixel_strobe;
    logic [9:0]  NextX, NextY, fb_x, fb_y, ig_x, ig_y;
    logic [1:0]  fb_frame, ig_frame;
    logic        fb_flip, ig_flip;
    logic [12:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_q;
    logic        is_fireboy, is_icegirl, busy, overrun;
    logic [7:0]  fireboy_data, icegirl_data;

    int s_nx, s_ny, s_fbx, s_fby, s_igx, s_igy, s_fbf, s_igf, s_fbflip, s_igflip;
    assign NextX    = 10'(s_nx);
    assign NextY    = 10'(s_ny);
    assign fb_x     = 10'(s_fbx);
    assign fb_y     = 10'(s_fby);
    assign ig_x     = 10'(s_igx);
    assign ig_y     = 10'(s_igy);
    assign fb_frame = 2'(s_fbf);
    assign ig_frame = 2'(s_igf);
    assign fb_flip  = 1'(s_fbflip);
    assign ig_flip  = 1'(s_igflip);

    sprite_fetch_scheduler dut (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_strobe(pixel_strobe),
        .NextX(NextX), .NextY(NextY), .fb_x(fb_x), .fb_y(fb_y), .ig_x(ig_x), .ig_y(ig_y),
        .fb_frame(fb_frame), .ig_frame(ig_frame), .fb_flip(fb_flip), .ig_flip(ig_flip),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_q(rom_q),
        .is_fireboy(is_fireboy), .fireboy_data(fireboy_data),
        .is_icegirl(is_icegirl), .icegirl_data(icegirl_data),
        .busy(busy), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM; returns noise when not read so stale data is never silently correct.
    logic [7:0] rom_mem [0:8191];
    always @(posedge Clk) rom_q <= rom_rd ? rom_mem[rom_addr] : 8'($urandom);

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int   last_addr;
    bit   exp_isfb, exp_isig, exp_ovr;
    int   exp_fbd, exp_igd;

    function automatic bit m_hit(int px, int py, int ox, int oy);
        return (px >= ox) && (px < ox + 32) && (py >= oy) && (py < oy + 32);
    endfunction

    function automatic int m_addr(int px, int py, int ox, int oy, int frame, int flip, int base);
        int dx, dy;
        dx = px - ox;
        dy = py - oy;
        if (flip != 0) dx = 31 - dx;
        return (base + frame * 1024 + dy * 32 + dx) % 8192;
    endfunction

    task automatic model_reset();
        last_addr = 0; exp_isfb = 0; exp_isig = 0; exp_fbd = 0; exp_igd = 0; exp_ovr = 0;
    endtask

    // One full pixel sequence with cycle-by-cycle checks; optionally scrambles inputs mid-flight.
    task automatic run_pixel(input int nx, input int ny, input bit scramble);
        bit hf, hi;
        int af, ai;
        int sv [10];
        hf = m_hit(nx, ny, s_fbx, s_fby);
        hi = m_hit(nx, ny, s_igx, s_igy);
        af = hf ? m_addr(nx, ny, s_fbx, s_fby, s_fbf, s_fbflip, 0) : 0;
        ai = hi ? m_addr(nx, ny, s_igx, s_igy, s_igf, s_igflip, 4096) : 0;
        sv = '{s_nx, s_ny, s_fbx, s_fby, s_igx, s_igy, s_fbf, s_igf, s_fbflip, s_igflip};
        s_nx = nx; s_ny = ny; pixel_strobe = 1'b1;
        @(posedge Clk); #1;
        pixel_strobe = 1'b0;
        if (scramble) begin
            s_nx = int'($urandom_range(0, 1023)); s_ny = int'($urandom_range(0, 1023));
            s_fbx = int'($urandom_range(0, 1023)); s_igy = int'($urandom_range(0, 1023));
            s_fbf = int'($urandom_range(0, 3)); s_igflip = int'($urandom_range(0, 1));
        end
        if (hf) last_addr = af;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fb_busy got %0b exp 1", busy); end
        n_checks++; if (rom_rd !== hf) begin n_fail++; $display("FAIL fb_rd got %0b exp %0b", rom_rd, hf); end
        n_checks++; if (rom_addr !== 13'(last_addr)) begin n_fail++; $display("FAIL fb_addr got %0d exp %0d", rom_addr, last_addr); end
        @(posedge Clk); #1;
        if (hi) last_addr = ai;
        n_checks++; if (rom_rd !== hi) begin n_fail++; $display("FAIL ig_rd got %0b exp %0b", rom_rd, hi); end
        n_checks++; if (rom_addr !== 13'(last_addr)) begin n_fail++; $display("FAIL ig_addr got %0d exp %0d", rom_addr, last_addr); end
        @(posedge Clk); #1;
        n_checks++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL cap_rd got %0b exp 0", rom_rd); end
        n_checks++; if (is_fireboy !== exp_isfb || fireboy_data !== 8'(exp_fbd))
            begin n_fail++; $display("FAIL early_commit got %0b/%0h exp %0b/%0h", is_fireboy, fireboy_data, exp_isfb, exp_fbd); end
        @(posedge Clk); #1;
        exp_isfb = hf; exp_fbd = hf ? int'(rom_mem[af]) : 0;
        exp_isig = hi; exp_igd = hi ? int'(rom_mem[ai]) : 0;
        n_checks++; if (is_fireboy !== exp_isfb) begin n_fail++; $display("FAIL is_fireboy got %0b exp %0b", is_fireboy, exp_isfb); end
        n_checks++; if (fireboy_data !== 8'(exp_fbd)) begin n_fail++; $display("FAIL fireboy_data got %0h exp %0h", fireboy_data, exp_fbd); end
        n_checks++; if (is_icegirl !== exp_isig) begin n_fail++; $display("FAIL is_icegirl got %0b exp %0b", is_icegirl, exp_isig); end
        n_checks++; if (icegirl_data !== 8'(exp_igd)) begin n_fail++; $display("FAIL icegirl_data got %0h exp %0h", icegirl_data, exp_igd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy got %0b exp 0", busy); end
        n_checks++; if (overrun !== exp_ovr) begin n_fail++; $display("FAIL overrun got %0b exp %0b", overrun, exp_ovr); end
        {s_nx, s_ny, s_fbx, s_fby, s_igx, s_igy} = {sv[0], sv[1], sv[2], sv[3], sv[4], sv[5]};
        {s_fbf, s_igf, s_fbflip, s_igflip} = {sv[6], sv[7], sv[8], sv[9]};
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if ({rom_addr, rom_rd, is_fireboy, fireboy_data, is_icegirl, icegirl_data, busy, overrun} !== '0)
            begin n_fail++; $display("FAIL reset_outputs got addr=%0d rd=%0b fb=%0h ig=%0h busy=%0b ovr=%0b exp all 0",
                                     rom_addr, rom_rd, fireboy_data, icegirl_data, busy, overrun); end
        Reset_n = 1'b1;
        model_reset();
        @(posedge Clk); #1;
    endtask

    task automatic set_sprites(int fx, int fy, int ff, int fl, int ix, int iy, int igf, int il);
        s_fbx = fx; s_fby = fy; s_fbf = ff; s_fbflip = fl;
        s_igx = ix; s_igy = iy; s_igf = igf; s_igflip = il;
    endtask

    task automatic test_basic();
        set_sprites(100, 200, 1, 0, 900, 900, 0, 0);
        run_pixel(105, 203, 1'b0);
        n_checks++; if (fireboy_data !== 8'h07) begin n_fail++; $display("FAIL basic_data got %0h exp 07", fireboy_data); end
    endtask

    task automatic test_flip();
        set_sprites(100, 200, 1, 1, 900, 900, 0, 0);
        run_pixel(105, 203, 1'b0);
        n_checks++; if (last_addr != 1146) begin n_fail++; $display("FAIL flip_addr got %0d exp 1146", last_addr); end
    endtask

    task automatic test_overlap();
        set_sprites(100, 200, 1, 0, 90, 190, 0, 0);
        run_pixel(105, 203, 1'b1);
        n_checks++; if (rom_addr !== 13'd4527) begin n_fail++; $display("FAIL overlap_addr got %0d exp 4527", rom_addr); end
    endtask

    task automatic test_edges();
        set_sprites(1000, 200, 1, 0, 900, 900, 0, 0);
        run_pixel(1023, 203, 1'b0);
        run_pixel(5, 203, 1'b0);
        set_sprites(100, 990, 2, 0, 900, 900, 0, 0);
        run_pixel(131, 1023, 1'b0);
        run_pixel(132, 1023, 1'b0);
        n_checks++; if (fireboy_data !== 8'h00) begin n_fail++; $display("FAIL edge_miss_data got %0h exp 00", fireboy_data); end
    endtask

    task automatic test_random();
        int nx, ny;
        for (int i = 0; i < 40; i++) begin
            nx = int'($urandom_range(0, 1023));
            ny = int'($urandom_range(0, 1023));
            set_sprites(nx - int'($urandom_range(0, 40)), ny - int'($urandom_range(0, 40)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                        nx - int'($urandom_range(0, 40)), ny - int'($urandom_range(0, 40)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            if (s_fbx < 0) s_fbx = 0;
            if (s_fby < 0) s_fby = 0;
            if (s_igx < 0) s_igx = 0;
            if (s_igy < 0) s_igy = 0;
            run_pixel(nx, ny, 1'b1);
        end
    endtask

    task automatic test_overrun();
        set_sprites(100, 200, 1, 0, 900, 900, 0, 0);
        s_nx = 105; s_ny = 203; pixel_strobe = 1'b1;
        @(posedge Clk); #1;
        pixel_strobe = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early got %0b exp 0", overrun); end
        @(posedge Clk); #1;
        s_nx = 110; pixel_strobe = 1'b1;
        @(posedge Clk); #1;
        pixel_strobe = 1'b0;
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %0b exp 1", overrun); end
        n_checks++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL ovr_rd got %0b exp 0", rom_rd); end
        @(posedge Clk); #1;
        exp_isfb = 1; exp_fbd = int'(rom_mem[1125]); exp_isig = 0; exp_igd = 0; exp_ovr = 1; last_addr = 1125;
        n_checks++; if (is_fireboy !== 1'b1 || fireboy_data !== 8'(exp_fbd))
            begin n_fail++; $display("FAIL ovr_commit got %0b/%0h exp 1/%0h", is_fireboy, fireboy_data, exp_fbd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_busy got %0b exp 0", busy); end
        run_pixel(120, 210, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_sprites(100, 200, 1, 0, 90, 190, 0, 0);
        s_nx = 105; s_ny = 203; pixel_strobe = 1'b1;
        @(posedge Clk); #1;
        pixel_strobe = 1'b0;
        @(posedge Clk); #1;
        n_checks++; if (rom_rd !== 1'b1) begin n_fail++; $display("FAIL mid_pre_rd got %0b exp 1", rom_rd); end
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({rom_addr, rom_rd, is_fireboy, fireboy_data, is_icegirl, icegirl_data, busy, overrun} !== '0)
            begin n_fail++; $display("FAIL mid_reset got addr=%0d rd=%0b fb=%0h ig=%0h busy=%0b ovr=%0b exp all 0",
                                     rom_addr, rom_rd, fireboy_data, icegirl_data, busy, overrun); end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        model_reset();
        @(posedge Clk); #1;
        n_checks++; if (is_fireboy !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_commit got fb=%0b busy=%0b exp 0/0", is_fireboy, busy); end
        run_pixel(105, 203, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) rom_mem[i] = 8'($urandom);
        rom_mem[1125] = 8'h07;
        pixel_strobe = 1'b0;
        s_nx = 0; s_ny = 0;
        set_sprites(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic();
        test_flip();
        test_overlap();
        test_edges();
        test_random();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
